// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB3/APB4 requester bridging a valid/ready command/response pair onto an APB segment
// Optional wait-state timeout abort: define KVIPS_APB_REQ_TIMEOUT_EN
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSEL    = 4,
    parameter int SEL_LSB = 12,
    parameter int APB4    = 1,
    parameter int TIMEOUT = 256
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [NSEL-1:0]     PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SW     = (NSEL > 1) ? $clog2(NSEL) : 1;
    localparam logic [SW:0] NSEL_V = (SW+1)'(NSEL);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nxt;

    logic [SW-1:0]     slot;
    logic              decode_err;
    logic              timed_out;
    logic [NSEL-1:0]   psel_nxt;
    logic              penable_nxt, pwrite_nxt, err_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt, rdata_nxt;
    logic [STRB_W-1:0] pstrb_nxt;
    logic [2:0]        pprot_nxt;

    assign slot       = cmd_addr[SEL_LSB +: SW];
    assign decode_err = ({1'b0, slot} >= NSEL_V);
    assign cmd_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);

`ifdef KVIPS_APB_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT - 1));

    // ACCESS is only ever entered from SETUP, so clearing there restarts the count
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !PREADY)
                wait_cnt <= wait_cnt + CW'(1);
            if (cmd_valid && cmd_ready)
                rsp_timeout <= 1'b0;
            else if (timed_out)
                rsp_timeout <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        psel_nxt    = PSEL;
        penable_nxt = PENABLE;
        paddr_nxt   = PADDR;
        pwrite_nxt  = PWRITE;
        pwdata_nxt  = PWDATA;
        pstrb_nxt   = PSTRB;
        pprot_nxt   = PPROT;
        rdata_nxt   = rsp_rdata;
        err_nxt     = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b0;
                    if (decode_err) begin
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt  = SETUP;
                        psel_nxt   = NSEL'(1) << slot;
                        paddr_nxt  = cmd_addr;
                        pwrite_nxt = cmd_write;
                        pwdata_nxt = cmd_write ? cmd_wdata : '0;
                        pstrb_nxt  = !cmd_write ? '0 : ((APB4 != 0) ? cmd_strb : {STRB_W{1'b1}});
                        pprot_nxt  = (APB4 != 0) ? cmd_prot : 3'b000;
                    end
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                // a completer ready on the timeout edge still completes normally
                if (PREADY) begin
                    rdata_nxt   = PWRITE ? '0 : PRDATA;
                    err_nxt     = PSLVERR;
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    state_nxt   = RESP;
                end else if (timed_out) begin
                    rdata_nxt   = '0;
                    err_nxt     = 1'b1;
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= 3'b000;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PADDR     <= paddr_nxt;
            PWRITE    <= pwrite_nxt;
            PWDATA    <= pwdata_nxt;
            PSTRB     <= pstrb_nxt;
            PPROT     <= pprot_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester (APB4/NSEL=4 and APB3/NSEL=3 instances)
module tb_apb_requester;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_write, rsp_ready, PREADY, PSLVERR;
    logic [31:0] cmd_addr, cmd_wdata, PRDATA;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic [3:0]  PSEL, PSTRB;
    logic [2:0]  PPROT;

    logic        cmd_ready_b, rsp_valid_b, rsp_err_b, rsp_timeout_b, PENABLE_b, PWRITE_b;
    logic [31:0] rsp_rdata_b, PADDR_b, PWDATA_b;
    logic [2:0]  PSEL_b;
    logic [3:0]  PSTRB_b;
    logic [2:0]  PPROT_b;

    int passed = 0;
    int total  = 0;

    always #5 PCLK = ~PCLK;

    apb_requester #(.NSEL(4), .APB4(1), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_requester #(.NSEL(3), .APB4(0), .TIMEOUT(8)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .rsp_timeout(rsp_timeout_b), .PADDR(PADDR_b), .PSEL(PSEL_b), .PENABLE(PENABLE_b), .PWRITE(PWRITE_b),
        .PWDATA(PWDATA_b), .PSTRB(PSTRB_b), .PPROT(PPROT_b), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else passed++;
        total++; if (cmd_ready_b !== 1'b1) $display("FAIL rst_cmd_ready_b got %b exp 1", cmd_ready_b); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE} !== 5'b0)
            $display("FAIL rst_flags got %b exp 00000", {rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE}); else passed++;
        total++; if ({PSEL, PADDR, PWDATA, PSTRB, PPROT, rsp_rdata} !== '0)
            $display("FAIL rst_buses got psel=%h paddr=%h pwdata=%h pstrb=%h pprot=%h rdata=%h exp all 0",
                     PSEL, PADDR, PWDATA, PSTRB, PPROT, rsp_rdata); else passed++;
    endtask

    task automatic test_write;
        PREADY = 1'b1;
        send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        total++; if ({PSEL, PENABLE, PWRITE} !== 6'b0010_0_1)
            $display("FAIL wr_setup got psel=%b pen=%b pwr=%b exp 0010 0 1", PSEL, PENABLE, PWRITE); else passed++;
        total++; if ({PADDR, PWDATA, PSTRB, PPROT} !== {32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010})
            $display("FAIL wr_setup_data got %h %h %h %b exp 00001004 deadbeef f 010", PADDR, PWDATA, PSTRB, PPROT); else passed++;
        total++; if ({cmd_ready, rsp_valid} !== 2'b00)
            $display("FAIL wr_busy got cmd_ready=%b rsp_valid=%b exp 0 0", cmd_ready, rsp_valid); else passed++;
        total++; if (PSEL_b !== 3'b010) $display("FAIL wr_psel_b got %b exp 010", PSEL_b); else passed++;
        tick;
        total++; if ({PSEL, PENABLE, rsp_valid} !== 6'b0010_1_0)
            $display("FAIL wr_access got psel=%b pen=%b rv=%b exp 0010 1 0", PSEL, PENABLE, rsp_valid); else passed++;
        tick;
        total++; if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 7'b1_0_0000_0)
            $display("FAIL wr_resp got rv=%b err=%b psel=%b pen=%b exp 1 0 0000 0", rsp_valid, rsp_err, PSEL, PENABLE); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rdata got %h exp 00000000", rsp_rdata); else passed++;
        total++; if (PADDR !== 32'h0000_1004) $display("FAIL wr_paddr_hold got %h exp 00001004", PADDR); else passed++;
        handshake;
        total++; if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL wr_done got rv=%b cmd_ready=%b exp 0 1", rsp_valid, cmd_ready); else passed++;
    endtask

    task automatic test_read_wait;
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        send(1'b0, 32'h0000_3000, 32'hAAAA_5555, 4'hF, 3'b000);
        total++; if ({PSEL, PWRITE, PSTRB, PWDATA} !== {4'b1000, 1'b0, 4'h0, 32'h0})
            $display("FAIL rd_setup got psel=%b pwr=%b pstrb=%h pwdata=%h exp 1000 0 0 0", PSEL, PWRITE, PSTRB, PWDATA); else passed++;
        total++; if ({rsp_valid_b, rsp_err_b, PSEL_b, rsp_rdata_b} !== {1'b1, 1'b1, 3'b000, 32'h0})
            $display("FAIL dec_err_b got rv=%b err=%b psel=%b rdata=%h exp 1 1 000 0", rsp_valid_b, rsp_err_b, PSEL_b, rsp_rdata_b); else passed++;
        tick;
        for (int i = 0; i < 4; i++) begin
            total++; if ({PENABLE, PSEL, PADDR, rsp_valid} !== {1'b1, 4'b1000, 32'h0000_3000, 1'b0})
                $display("FAIL rd_wait%0d got pen=%b psel=%b paddr=%h rv=%b exp 1 1000 00003000 0", i, PENABLE, PSEL, PADDR, rsp_valid); else passed++;
            if (i == 3) PREADY = 1'b1;
            tick;
        end
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1234_5678})
            $display("FAIL rd_resp got rv=%b err=%b rdata=%h exp 1 0 12345678", rsp_valid, rsp_err, rsp_rdata); else passed++;
        PRDATA = 32'hCAFE_F00D;
        handshake;
        total++; if ({cmd_ready, cmd_ready_b} !== 2'b11)
            $display("FAIL rd_done got %b exp 11", {cmd_ready, cmd_ready_b}); else passed++;
    endtask

    task automatic test_upper_bits;
        PREADY = 1'b1;
        send(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000);
        total++; if ({PSEL, PADDR, PSEL_b} !== {4'b0001, 32'h0000_4000, 3'b001})
            $display("FAIL hi_bits got psel=%b paddr=%h psel_b=%b exp 0001 00004000 001", PSEL, PADDR, PSEL_b); else passed++;
        total++; if (rsp_rdata_b !== 32'h0) $display("FAIL rdata_cleared_b got %h exp 0", rsp_rdata_b); else passed++;
        tick;
        tick;
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D})
            $display("FAIL hi_resp got rv=%b err=%b rdata=%h exp 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata); else passed++;
        handshake;
    endtask

    task automatic test_slverr_backpressure;
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        send(1'b1, 32'h0000_2010, 32'h0BAD_0BAD, 4'hF, 3'b000);
        tick;
        tick;
        PSLVERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0})
                $display("FAIL slverr_hold%0d got rv=%b err=%b cr=%b rdata=%h exp 1 1 0 0", i, rsp_valid, rsp_err, cmd_ready, rsp_rdata); else passed++;
            tick;
        end
        handshake;
        total++; if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL slverr_done got rv=%b cr=%b exp 0 1", rsp_valid, cmd_ready); else passed++;
    endtask

    task automatic test_apb3_strobes;
        PREADY = 1'b1;
        send(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'h3, 3'b101);
        total++; if ({PSTRB, PPROT} !== {4'h3, 3'b101})
            $display("FAIL apb4_strb got pstrb=%h pprot=%b exp 3 101", PSTRB, PPROT); else passed++;
        total++; if ({PSTRB_b, PPROT_b, PWDATA_b} !== {4'hF, 3'b000, 32'h5555_AAAA})
            $display("FAIL apb3_strb got pstrb=%h pprot=%b pwdata=%h exp f 000 5555aaaa", PSTRB_b, PPROT_b, PWDATA_b); else passed++;
        tick;
        tick;
        total++; if ({rsp_valid, rsp_err, rsp_valid_b, rsp_err_b} !== 4'b1010)
            $display("FAIL apb3_resp got %b exp 1010", {rsp_valid, rsp_err, rsp_valid_b, rsp_err_b}); else passed++;
        handshake;
    endtask

    task automatic test_timeout;
        PREADY = 1'b0;
        send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
        tick;
`ifdef KVIPS_APB_REQ_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            total++; if ({PENABLE, rsp_valid} !== 2'b10)
                $display("FAIL to_wait%0d got pen=%b rv=%b exp 1 0", i, PENABLE, rsp_valid); else passed++;
            tick;
        end
        total++; if ({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, rsp_rdata} !== {3'b111, 4'b0, 1'b0, 32'h0})
            $display("FAIL to_abort got rv=%b err=%b to=%b psel=%b pen=%b rdata=%h exp 1 1 1 0 0 0",
                     rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, rsp_rdata); else passed++;
        total++; if (rsp_timeout_b !== 1'b1) $display("FAIL to_abort_b got %b exp 1", rsp_timeout_b); else passed++;
        handshake;
        send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
        total++; if (rsp_timeout !== 1'b0) $display("FAIL to_cleared got %b exp 0", rsp_timeout); else passed++;
        tick;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) PREADY = 1'b1;
            tick;
        end
        total++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'hCAFE_F00D})
            $display("FAIL to_race got rv=%b err=%b to=%b rdata=%h exp 1 0 0 cafef00d", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); else passed++;
`else
        for (int i = 0; i < 12; i++) begin
            total++; if ({PENABLE, rsp_valid, rsp_timeout} !== 3'b100)
                $display("FAIL nto_wait%0d got pen=%b rv=%b to=%b exp 1 0 0", i, PENABLE, rsp_valid, rsp_timeout); else passed++;
            if (i == 11) PREADY = 1'b1;
            tick;
        end
        total++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'hCAFE_F00D})
            $display("FAIL nto_resp got rv=%b err=%b to=%b rdata=%h exp 1 0 0 cafef00d", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); else passed++;
`endif
        handshake;
        PREADY = 1'b1;
    endtask

    task automatic test_reset_mid;
        PREADY = 1'b0;
        send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000);
        tick;
        total++; if ({PENABLE, PSEL} !== 5'b1_0100)
            $display("FAIL mid_access got pen=%b psel=%b exp 1 0100", PENABLE, PSEL); else passed++;
        #2 PRESET = 1'b1;
        #1;
        total++; if ({PSEL, PENABLE, cmd_ready, PSEL_b} !== {4'b0, 1'b0, 1'b1, 3'b0})
            $display("FAIL mid_async got psel=%b pen=%b cr=%b psel_b=%b exp 0 0 1 0", PSEL, PENABLE, cmd_ready, PSEL_b); else passed++;
        tick;
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({rsp_valid, PSEL, cmd_ready} !== {1'b0, 4'b0, 1'b1})
                $display("FAIL mid_norsp%0d got rv=%b psel=%b cr=%b exp 0 0 1", i, rsp_valid, PSEL, cmd_ready); else passed++;
            tick;
        end
    endtask

    initial begin
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hCAFE_F00D;
        tick;
        tick;
        PRESET = 1'b0;
        test_reset;
        test_write;
        test_read_wait;
        test_upper_bits;
        test_slverr_backpressure;
        test_apb3_strobes;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
